// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports and the memory command/return port of mem_arbiter.
// Latency: none, this is wiring only.
// Backpressure: carried by the req_ready / mem_ready signals it contains.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // port 0: CPU
    logic              m0_req_valid;
    logic              m0_req_ready;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_rsp_valid;
    logic [DATA_W-1:0] m0_rdata;
    // port 1: program loader
    logic              m1_req_valid;
    logic              m1_req_ready;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_rsp_valid;
    logic [DATA_W-1:0] m1_rdata;
    // memory macro
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  m0_req_valid, m0_we, m0_addr, m0_wdata,
        output m0_req_ready, m0_rsp_valid, m0_rdata,
        input  m1_req_valid, m1_we, m1_addr, m1_wdata,
        output m1_req_ready, m1_rsp_valid, m1_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    // requester / memory side
    modport master (
        output m0_req_valid, m0_we, m0_addr, m0_wdata,
        input  m0_req_ready, m0_rsp_valid, m0_rdata,
        output m1_req_valid, m1_we, m1_addr, m1_wdata,
        input  m1_req_ready, m1_rsp_valid, m1_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between CPU (port 0) and loader (port 1); define MEM_ARB_RR_EN for round-robin, else fixed priority with MAX_WAIT bound.
// Latency: accept->rsp_valid is 3 cycles for a read (mem_ready=1, memory latency 1) and 2 for a write; one transaction in flight.
// Backpressure: req_ready only in IDLE; mem_ready low stretches CMD; responses are never back-pressured.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 0 = CPU, 1 = loader
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              last_q, last_d;        // port granted most recently

    logic grant0, grant1;
    logic req_ready0, req_ready1;
    logic rsp_valid0, rsp_valid1;
    logic mem_valid;

    // Pick the winning port among the currently valid requests.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (bus.m0_req_valid && bus.m1_req_valid) begin
            grant1 = ~last_q;
            grant0 = last_q;
        end else begin
            grant0 = bus.m0_req_valid;
            grant1 = bus.m1_req_valid;
        end
`else
        grant1 = bus.m1_req_valid &&
                 (!bus.m0_req_valid || wait_cnt_q == CNT_W'(MAX_WAIT));
        grant0 = bus.m0_req_valid && !grant1;
`endif
    end

    // Next-state, command latching, read-data capture and handshake outputs.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        wait_cnt_d = wait_cnt_q;
        last_d     = last_q;
        req_ready0 = 1'b0;
        req_ready1 = 1'b0;
        rsp_valid0 = 1'b0;
        rsp_valid1 = 1'b0;
        mem_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready0 = grant0;
                req_ready1 = grant1;
                if (grant0 || grant1) begin
                    owner_d = grant1;
                    we_d    = grant1 ? bus.m1_we    : bus.m0_we;
                    addr_d  = grant1 ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = grant1 ? bus.m1_wdata : bus.m0_wdata;
                    last_d  = grant1;
                    state_d = CMD;
                end
`ifndef MEM_ARB_RR_EN
                // count CPU wins that left the loader waiting
                if (!bus.m1_req_valid || grant1) begin
                    wait_cnt_d = '0;
                end else if (grant0) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            CMD: begin
                mem_valid = 1'b1;
                if (bus.mem_ready) begin
                    state_d = we_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    if (owner_q) rdata1_d = bus.mem_rdata;
                    else         rdata0_d = bus.mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid0 = !owner_q;
                rsp_valid1 = owner_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            wait_cnt_q <= '0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            wait_cnt_q <= wait_cnt_d;
            last_q     <= last_d;
        end
    end

    assign bus.m0_req_ready = req_ready0;
    assign bus.m1_req_ready = req_ready1;
    assign bus.m0_rsp_valid = rsp_valid0;
    assign bus.m1_rsp_valid = rsp_valid1;
    assign bus.m0_rdata     = rdata0_q;
    assign bus.m1_rdata     = rdata1_q;
    assign bus.mem_valid    = mem_valid;
    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;

endmodule
